// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

  localparam int unsigned BE_W   = 4;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic              we;
    logic [31:0]       addr;
    logic [WORD_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

  // Access size is inferred from the enable pattern: full word needs addr[1:0]=0,
  // a contiguous halfword needs addr[0]=0.
  function automatic logic is_misaligned(input logic [31:0] addr, input logic [BE_W-1:0] be);
    logic mis;
    mis = 1'b0;
    if (be == 4'b1111 && addr[1:0] != 2'b00)
      mis = 1'b1;
    else if ((be == 4'b0011 || be == 4'b1100) && addr[0])
      mis = 1'b1;
    return mis;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the MEM stage (master) and the responder (slave).
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Word array: synchronous byte-enabled write, combinational read at the same index.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [BE_W-1:0]                be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [WORD_W-1:0]              wdata,
  output logic [WORD_W-1:0]              rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (be[i])
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Latency-programmable load/store responder for the core's data port.
// Optional DMEM_ERR_EN: flags misaligned/out-of-range accesses and suppresses their effect.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  req_t              req_q;
  logic [WORD_W-1:0] rdata_q;
  logic              err_q;
  logic              accept, access, req_err, wr_en, ready;
  logic [WORD_W-1:0] arr_rdata;
  logic [AW-1:0]     word_idx;

  assign word_idx = req_q.addr[AW+1:2];

`ifdef DMEM_ERR_EN
  assign req_err = is_misaligned(req_q.addr, req_q.be) || (req_q.addr[31:AW+2] != '0);
`else
  assign req_err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    access  = 1'b0;
    ready   = 1'b0;
    unique case (state)
      IDLE: begin
        ready = rst;
        if (bus.req_valid) begin
          accept  = 1'b1;
          cnt_n   = 4'(LATENCY - 1);
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          access  = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Gating with rst drops a store whose access edge coincides with reset.
  assign wr_en = access && req_q.we && !req_err && rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        req_q.we    <= bus.req_we;
        req_q.addr  <= bus.req_addr;
        req_q.wdata <= bus.req_wdata;
        req_q.be    <= bus.req_be;
      end
      if (access) begin
        rdata_q <= (req_q.we || req_err) ? '0 : arr_rdata;
        err_q   <= req_err;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (wr_en),
    .be    (req_q.be),
    .addr  (word_idx),
    .wdata (req_q.wdata),
    .rdata (arr_rdata)
  );

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder; expectations track DMEM_ERR_EN when it is defined.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned LAT    = 2;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int          BUDGET = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_hs_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic model_err(input logic [31:0] addr, input logic [3:0] be);
`ifdef DMEM_ERR_EN
    logic mis, oor;
    mis = (be == 4'hF && addr[1:0] != 2'b00) || ((be == 4'h3 || be == 4'hC) && addr[0]);
    oor = (addr >> (AW + 2)) != 0;
    return mis || oor;
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input bit track, output int acc);
    bit          ok;
    exp_t        e;
    logic [AW-1:0] idx;
    ok  = 1'b0;
    acc = -1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    bus.req_valid = 1'b1;
    for (int i = 0; i < BUDGET && !ok; i++) begin
      ok = bus.req_ready;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    if (!ok) begin
      check_eq("req_accept_timeout", 32'd0, 32'd1);
      return;
    end
    acc = cyc;
    if (track) begin
      idx     = addr[AW+1:2];
      e.err   = model_err(addr, be);
      e.acc_cyc = cyc;
      if (we) begin
        e.rdata = '0;
        if (!e.err)
          for (int b = 0; b < 4; b++)
            if (be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        e.rdata = e.err ? 32'd0 : model[idx];
      end
      sb.push_back(e);
    end
  endtask

  task automatic wait_rsp(input int hold, input bit chk_busy);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      if (bus.rsp_valid) seen = 1'b1;
      else begin
        if (chk_busy) check_eq("req_ready_busy", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
      end
    end
    if (!seen) begin
      check_eq("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      check_eq("unexpected_rsp", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check_eq("latency", 32'(cyc - e.acc_cyc), 32'(LAT));
    check_eq("rsp_rdata", bus.rsp_rdata, e.rdata);
    check_eq("rsp_err", 32'(bus.rsp_err), 32'(e.err));
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("hold_rdata", bus.rsp_rdata, e.rdata);
      if (chk_busy) check_eq("req_ready_resp", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    last_hs_cyc = cyc;
    check_eq("valid_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int acc;
    bit saw_valid;
    logic [31:0] a, d;
    logic [3:0]  be;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b0;

    // Reset then idle
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("ready_in_reset", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    #1;
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check_eq("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    @(posedge clk);
    #1;

    // Store then load, then byte-enabled merge and empty enable
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, acc); wait_rsp(0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 1'b1, acc);        wait_rsp(0, 1'b0);
    do_req(1'b1, 32'h10, 32'h11223344, 4'h5, 1'b1, acc); wait_rsp(0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, acc);        wait_rsp(0, 1'b0);
    check_eq("be_merge_const", model[4], 32'hDE22BE44);
    do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b1, acc); wait_rsp(0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 1'b1, acc);        wait_rsp(5, 1'b0);

    // Mid-operation request held until idle
    do_req(1'b1, 32'h40, 32'hAAAA5555, 4'hF, 1'b1, acc);
    bus.req_we = 1'b0; bus.req_addr = 32'h40; bus.req_be = 4'hF; bus.req_valid = 1'b1;
    wait_rsp(3, 1'b1);
    do_req(1'b0, 32'h40, 32'h0, 4'hF, 1'b1, acc);
    check_eq("second_accept_cycle", 32'(acc), 32'(last_hs_cyc + 1));
    wait_rsp(0, 1'b0);

    // Reset during WAIT drops the store
    do_req(1'b1, 32'h20, 32'h12345678, 4'hF, 1'b1, acc); wait_rsp(0, 1'b0);
    do_req(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0, acc);
    rst = 1'b0;
    saw_valid = 1'b0;
    @(posedge clk);
    #1;
    saw_valid |= bus.rsp_valid;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      saw_valid |= bus.rsp_valid;
    end
    check_eq("no_rsp_after_reset", 32'(saw_valid), 32'd0);
    do_req(1'b0, 32'h20, 32'h0, 4'hF, 1'b1, acc); wait_rsp(0, 1'b0);

    // Misalignment and out-of-range wrap
    do_req(1'b1, 32'h0, 32'h0BADF00D, 4'hF, 1'b1, acc);           wait_rsp(0, 1'b0);
    do_req(1'b0, 32'h13, 32'h0, 4'hF, 1'b1, acc);                 wait_rsp(0, 1'b0);
    do_req(1'b1, 32'(DEPTH * 4), 32'h77778888, 4'hF, 1'b1, acc);  wait_rsp(0, 1'b0);
    do_req(1'b0, 32'h0, 32'h0, 4'hF, 1'b1, acc);                  wait_rsp(0, 1'b0);
`ifdef DMEM_ERR_EN
    check_eq("word0_kept_const", model[0], 32'h0BADF00D);
`else
    check_eq("word0_wrap_const", model[0], 32'h77778888);
`endif

    // Random store/load pairs over a small aligned window
    for (int i = 0; i < 8; i++) begin
      a  = 32'($urandom_range(0, 15)) << 2;
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      do_req(1'b1, a, d, 4'hF, 1'b1, acc);  wait_rsp(0, 1'b0);
      do_req(1'b1, a, ~d, be, 1'b1, acc);   wait_rsp($urandom_range(0, 2), 1'b0);
      do_req(1'b0, a, 32'h0, 4'hF, 1'b1, acc); wait_rsp(0, 1'b1);
    end

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
